// File: rtl/vga_circle_render.sv
// Pixel-colour stage: 3-cycle pipelined circle hit test (disc/ring/border/bars)
// with a per-frame radius animation FSM; syncs delayed to match the pipeline.
module vga_circle_render #(
  parameter int unsigned H_RES       = 640,
  parameter int unsigned V_RES       = 480,
  parameter int unsigned CX          = 320,
  parameter int unsigned CY          = 240,
  parameter int unsigned R_MIN       = 16,
  parameter int unsigned R_MAX       = 200,
  parameter int unsigned R_STEP      = 2,
  parameter int unsigned HOLD_FRAMES = 30,
  parameter int unsigned RING_W      = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [11:0] i_x,
  input  logic [11:0] i_y,
  input  logic        i_hblank,
  input  logic        i_vblank,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic [1:0]  i_sel,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_red,
  output logic        o_grn,
  output logic        o_blu,
  output logic [9:0]  o_radius
);

  localparam int unsigned HW      = (HOLD_FRAMES > 2) ? $clog2(HOLD_FRAMES) : 1;
  localparam int unsigned RIN_RST = (R_MIN > RING_W) ? (R_MIN - RING_W) : 0;
  localparam logic [11:0] CX_W    = 12'(CX);
  localparam logic [11:0] CY_W    = 12'(CY);
  localparam logic [11:0] X_LAST  = 12'(H_RES - 1);
  localparam logic [11:0] Y_LAST  = 12'(V_RES - 1);

  typedef enum logic [1:0] {
    ST_GROW,
    ST_HOLD_HI,
    ST_SHRINK,
    ST_HOLD_LO
  } state_t;

  state_t          state_q, state_d;
  logic [9:0]      r_q, r_d, rin_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [1:0]      mode_q;
  logic [19:0]     r2_q, r2_d, rin2_q, rin2_d;
  logic            vblank_q;
  logic            frame_evt;

  assign frame_evt = i_vblank & ~vblank_q;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    hold_d  = hold_q;
    if (frame_evt) begin
      case (state_q)
        ST_GROW: begin
          if (({1'b0, r_q} + 11'(R_STEP)) >= 11'(R_MAX)) begin
            r_d     = 10'(R_MAX);
            hold_d  = HW'(HOLD_FRAMES - 1);
            state_d = ST_HOLD_HI;
          end else begin
            r_d = r_q + 10'(R_STEP);
          end
        end
        ST_HOLD_HI: begin
          if (hold_q == '0) state_d = ST_SHRINK;
          else              hold_d  = hold_q - HW'(1);
        end
        ST_SHRINK: begin
          if (r_q <= 10'(R_MIN + R_STEP)) begin
            r_d     = 10'(R_MIN);
            hold_d  = HW'(HOLD_FRAMES - 1);
            state_d = ST_HOLD_LO;
          end else begin
            r_d = r_q - 10'(R_STEP);
          end
        end
        ST_HOLD_LO: begin
          if (hold_q == '0) state_d = ST_GROW;
          else              hold_d  = hold_q - HW'(1);
        end
        default: state_d = ST_GROW;
      endcase
    end
    // Squares are taken from the post-step radius so the new frame uses them.
    rin_d  = (r_d > 10'(RING_W)) ? (r_d - 10'(RING_W)) : '0;
    r2_d   = 20'(r_d) * 20'(r_d);
    rin2_d = 20'(rin_d) * 20'(rin_d);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_GROW;
      r_q      <= 10'(R_MIN);
      hold_q   <= '0;
      mode_q   <= '0;
      r2_q     <= 20'(R_MIN * R_MIN);
      rin2_q   <= 20'(RIN_RST * RIN_RST);
      vblank_q <= 1'b1;
    end else begin
      vblank_q <= i_vblank;
      state_q  <= state_d;
      r_q      <= r_d;
      hold_q   <= hold_d;
      if (frame_evt) begin
        mode_q <= i_sel;
        r2_q   <= r2_d;
        rin2_q <= rin2_d;
      end
    end
  end

  assign o_radius = r_q;

  // Stage 1: absolute offsets from the centre
  logic [11:0] dx_d, dy_d;
  logic [11:0] s1_dx_q, s1_dy_q, s1_x_q, s1_y_q;
  logic        s1_blank_q, s1_hs_q, s1_vs_q;

  assign dx_d = (i_x >= CX_W) ? (i_x - CX_W) : (CX_W - i_x);
  assign dy_d = (i_y >= CY_W) ? (i_y - CY_W) : (CY_W - i_y);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_dx_q    <= '0;
      s1_dy_q    <= '0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_blank_q <= 1'b1;
      s1_hs_q    <= 1'b1;
      s1_vs_q    <= 1'b1;
    end else begin
      s1_dx_q    <= dx_d;
      s1_dy_q    <= dy_d;
      s1_x_q     <= i_x;
      s1_y_q     <= i_y;
      s1_blank_q <= i_hblank | i_vblank;
      s1_hs_q    <= i_hsync;
      s1_vs_q    <= i_vsync;
    end
  end

  // Stage 2: squares
  logic [23:0] s2_dx2_q, s2_dy2_q;
  logic [11:0] s2_x_q, s2_y_q;
  logic        s2_blank_q, s2_hs_q, s2_vs_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s2_dx2_q   <= '0;
      s2_dy2_q   <= '0;
      s2_x_q     <= '0;
      s2_y_q     <= '0;
      s2_blank_q <= 1'b1;
      s2_hs_q    <= 1'b1;
      s2_vs_q    <= 1'b1;
    end else begin
      s2_dx2_q   <= 24'(s1_dx_q) * 24'(s1_dx_q);
      s2_dy2_q   <= 24'(s1_dy_q) * 24'(s1_dy_q);
      s2_x_q     <= s1_x_q;
      s2_y_q     <= s1_y_q;
      s2_blank_q <= s1_blank_q;
      s2_hs_q    <= s1_hs_q;
      s2_vs_q    <= s1_vs_q;
    end
  end

  // Stage 3: distance compare and colour select
  logic [24:0] d2;
  logic        in_disc, in_ring, on_border;
  logic [2:0]  rgb_d, rgb_q;
  logic        hs_q, vs_q;

  always_comb begin
    d2        = 25'(s2_dx2_q) + 25'(s2_dy2_q);
    in_disc   = d2 <= 25'(r2_q);
    in_ring   = in_disc && (d2 >= 25'(rin2_q));
    on_border = (s2_x_q == '0) || (s2_x_q == X_LAST) ||
                (s2_y_q == '0) || (s2_y_q == Y_LAST);
    rgb_d     = '0;
    if (!s2_blank_q) begin
      case (mode_q)
        2'b00:   rgb_d = in_disc ? 3'b111 : 3'b001;
        2'b01:   rgb_d = in_ring ? 3'b110 : 3'b000;
        2'b10:   rgb_d = on_border ? 3'b100 : (in_disc ? 3'b111 : 3'b000);
        default: rgb_d = s2_x_q[8:6];
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rgb_q <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else begin
      rgb_q <= rgb_d;
      hs_q  <= s2_hs_q;
      vs_q  <= s2_vs_q;
    end
  end

  assign o_red   = rgb_q[2];
  assign o_grn   = rgb_q[1];
  assign o_blu   = rgb_q[0];
  assign o_hsync = hs_q;
  assign o_vsync = vs_q;

endmodule
